// File: rtl/zion_riscv_isa_lib_bits_issue_stage_pkg.sv
// ============================================================================
// zion_riscv_isa_lib_pkg : opcode/funct constants and op-select type shared
// by the bit-operation issue stage.  Rev 1.0
// ============================================================================
`default_nettype none

package zion_riscv_isa_lib_pkg;

   localparam logic [6:0] c_OPC_OP    = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] c_OPC_LUI   = 7'b0110111;

   localparam logic [2:0] c_F3_AND    = 3'b111;
   localparam logic [2:0] c_F3_OR     = 3'b110;
   localparam logic [2:0] c_F3_XOR    = 3'b100;

   localparam logic [6:0] c_F7_BASE   = 7'b0000000;

   typedef struct packed {
      logic and_en;
      logic or_en;
      logic xor_en;
   } bits_op_t;

endpackage

`default_nettype wire

// File: rtl/zion_riscv_isa_lib_bits_issue_stage_if.sv
// ============================================================================
// zion_riscv_isa_lib_bits_issue_stage_if : upstream/downstream handshake bus
// of the bit-operation issue stage.  Rev 1.0
// ============================================================================
`default_nettype none

interface zion_riscv_isa_lib_bits_issue_stage_if #(
   parameter int RV64 = 0
);
   localparam int XLEN = 32 * (RV64 + 1);

   logic            in_vld;
   logic            in_rdy;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;
   logic            flush;
   logic            out_vld;
   logic            out_rdy;
   logic            out_and_en;
   logic            out_or_en;
   logic            out_xor_en;
   logic [XLEN-1:0] out_s1;
   logic [XLEN-1:0] out_s2;
   logic [4:0]      out_rd;
   logic            illegal_pls;

   // Producer/consumer side (pipeline environment).
   modport master (
      output in_vld, in_instr, in_rs1_val, in_rs2_val, flush, out_rdy,
      input  in_rdy, out_vld, out_and_en, out_or_en, out_xor_en,
             out_s1, out_s2, out_rd, illegal_pls
   );

   // Issue-stage side.
   modport slave (
      input  in_vld, in_instr, in_rs1_val, in_rs2_val, flush, out_rdy,
      output in_rdy, out_vld, out_and_en, out_or_en, out_xor_en,
             out_s1, out_s2, out_rd, illegal_pls
   );

endinterface

`default_nettype wire

// File: rtl/zion_riscv_isa_lib_bits_issue_stage_decode.sv
// ============================================================================
// zion_riscv_isa_lib_bits_decode : combinational instruction -> op/operands.
// LUI decoding enabled by ZION_RISCV_BITS_ISSUE_LUI_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module zion_riscv_isa_lib_bits_decode
   import zion_riscv_isa_lib_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   output logic            o_legal,
   output bits_op_t        o_op,
   output logic [XLEN-1:0] o_s1,
   output logic [XLEN-1:0] o_s2,
   output logic [4:0]      o_rd
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic            w_is_op;
   logic            w_is_imm;
   logic [XLEN-1:0] w_imm_i;
   logic            w_unused;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];
   assign w_is_op  = (w_opcode == c_OPC_OP) && (w_funct7 == c_F7_BASE);
   assign w_is_imm = (w_opcode == c_OPC_OPIMM);
   assign w_imm_i  = XLEN'($signed(i_instr[31:20]));
   // rs1 index is resolved by the register file upstream.
   assign w_unused = ^i_instr[19:15];

`ifdef ZION_RISCV_BITS_ISSUE_LUI_EN
   logic [XLEN-1:0] w_imm_u;
   assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'h000}));
`endif

   always_comb begin
      o_legal = 1'b0;
      o_op    = '0;
      o_s1    = i_rs1_val;
      o_s2    = w_is_imm ? w_imm_i : i_rs2_val;
      o_rd    = i_instr[11:7];
      if (w_is_op || w_is_imm) begin
         case (w_funct3)
            c_F3_AND: begin o_op.and_en = 1'b1; o_legal = 1'b1; end
            c_F3_OR:  begin o_op.or_en  = 1'b1; o_legal = 1'b1; end
            c_F3_XOR: begin o_op.xor_en = 1'b1; o_legal = 1'b1; end
            default:  o_legal = 1'b0;
         endcase
      end
`ifdef ZION_RISCV_BITS_ISSUE_LUI_EN
      // LUI rides the OR unit as 0 | imm.
      if (w_opcode == c_OPC_LUI) begin
         o_legal     = 1'b1;
         o_op        = '0;
         o_op.or_en  = 1'b1;
         o_s1        = '0;
         o_s2        = w_imm_u;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/zion_riscv_isa_lib_bits_issue_stage.sv
// ============================================================================
// zion_riscv_isa_lib_bits_issue_stage : decode + 2-entry in-order issue FIFO
// for AND/OR/XOR(I). Optional LUI via ZION_RISCV_BITS_ISSUE_LUI_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module zion_riscv_isa_lib_bits_issue_stage
   import zion_riscv_isa_lib_pkg::*;
#(
   parameter int RV64 = 0
) (
   input  logic clk,
   input  logic rst,
   zion_riscv_isa_lib_bits_issue_stage_if.slave bus
);

   localparam int XLEN = 32 * (RV64 + 1);

   typedef struct packed {
      bits_op_t        op;
      logic [XLEN-1:0] s1;
      logic [XLEN-1:0] s2;
      logic [4:0]      rd;
   } entry_t;

   entry_t          r_mem [2];
   logic            r_wptr;
   logic            r_rptr;
   logic [1:0]      r_count;
   logic            r_ill;

   logic            w_legal;
   bits_op_t        w_op;
   logic [XLEN-1:0] w_s1;
   logic [XLEN-1:0] w_s2;
   logic [4:0]      w_rd;
   entry_t          w_entry;
   entry_t          w_head;
   logic            w_in_rdy;
   logic            w_out_vld;
   logic            w_in_fire;
   logic            w_push;
   logic            w_pop;

   zion_riscv_isa_lib_bits_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .i_instr   (bus.in_instr),
      .i_rs1_val (bus.in_rs1_val),
      .i_rs2_val (bus.in_rs2_val),
      .o_legal   (w_legal),
      .o_op      (w_op),
      .o_s1      (w_s1),
      .o_s2      (w_s2),
      .o_rd      (w_rd)
   );

   assign w_entry   = '{op: w_op, s1: w_s1, s2: w_s2, rd: w_rd};
   assign w_head    = r_mem[r_rptr];

   // Ready depends only on occupancy so out_rdy never reaches in_rdy.
   assign w_in_rdy  = ~r_count[1];
   assign w_out_vld = (r_count != 2'd0);
   assign w_in_fire = bus.in_vld & w_in_rdy & ~bus.flush;
   assign w_push    = w_in_fire & w_legal;
   assign w_pop     = w_out_vld & bus.out_rdy & ~bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_ill    <= 1'b0;
      end else if (bus.flush) begin
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_ill    <= 1'b0;
      end else begin
         r_ill <= w_in_fire & ~w_legal;
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Enables are gated so a drained slot never presents a stale op.
   assign bus.in_rdy      = w_in_rdy;
   assign bus.out_vld     = w_out_vld;
   assign bus.out_and_en  = w_head.op.and_en & w_out_vld;
   assign bus.out_or_en   = w_head.op.or_en  & w_out_vld;
   assign bus.out_xor_en  = w_head.op.xor_en & w_out_vld;
   assign bus.out_s1      = w_head.s1;
   assign bus.out_s2      = w_head.s2;
   assign bus.out_rd      = w_head.rd;
   assign bus.illegal_pls = r_ill;

endmodule

`default_nettype wire
